cache_ctrl_wb: RTL and testbench
================================

# cache_ctrl_wb

Parametrised write-back cache controller; next generation of the CPU/cache/RAM controller, sitting between the CPU port and the cache array / RAM model in the top level. Adds a real dirty-line write-back path to RAM, a registered RAM read/write handshake with timeout, full-line write-miss allocation without a fill fetch, and saturating hit/miss/write-back statistics. One request in flight at a time.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 512, cache line width in bits; OFFSET_W = clog2(LINE_W/8)
- TIMEOUT, 64, max cycles waiting for ram_ready before abort (>=2)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_read / cpu_write  in  1  request strobes, sampled in IDLE only
- cpu_address  in  ADDR_W;  cpu_write_data  in  LINE_W
- cpu_read_data  out  LINE_W  valid while done=1, held until next done
- done  out  1  one-cycle completion pulse;  error  out  1  one-cycle timeout pulse
- busy  out  1  high in every state except IDLE
- cache_read / cache_write  out  1  one-cycle lookup strobes
- cache_fill  out  1  one-cycle line install strobe (data on cache_write_data)
- cache_address  out  ADDR_W;  cache_write_data  out  LINE_W
- cache_hit / cache_miss / dirty_evicted  in  1  lookup result, valid the cycle after the strobe
- cache_read_data, evicted_data  in  LINE_W;  evicted_address  in  ADDR_W
- ram_req  out  1;  ram_we  out  1;  ram_address  out  ADDR_W;  ram_wdata  out  LINE_W
- ram_ready  in  1;  ram_rdata  in  LINE_W (valid with ram_ready)
- hit_count, miss_count, wb_count  out  CNT_W  saturating statistics

## Operation
- States: IDLE, LOOKUP, CHECK, WRITEBACK, FILL, RESPOND.
- IDLE: on cpu_read|cpu_write latch op, address, write data; -> LOOKUP. Both high: write wins. Requests while busy ignored (no queue).
- LOOKUP: drive cache_read or cache_write for exactly one cycle, cache_address = latched address; -> CHECK.
- CHECK: cache_hit -> hit_count++, capture cache_read_data for reads, -> RESPOND. cache_miss -> miss_count++; dirty_evicted -> WRITEBACK; else read -> FILL, write -> RESPOND (cache installed the full line on the write strobe; no fetch). Neither hit nor miss: stay in CHECK (counts toward TIMEOUT).
- WRITEBACK: ram_req=1, ram_we=1, ram_address = evicted_address with low OFFSET_W bits zeroed, ram_wdata = evicted_data (captured in CHECK). On ram_ready: wb_count++, -> FILL for reads, RESPOND for writes.
- FILL: ram_req=1, ram_we=0, ram_address = latched address line-aligned. On ram_ready: cache_fill=1 one cycle with cache_write_data = ram_rdata, capture ram_rdata into cpu_read_data, -> RESPOND.
- RESPOND: done=1 one cycle; -> IDLE.
- Timeout: wait counter cleared on entering CHECK/WRITEBACK/FILL; reaching TIMEOUT -> error=1 one cycle, drop ram_req, no done, no cache_fill, -> IDLE.
- Counters saturate at 2^CNT_W-1, never wrap.

## Timing
- Reset (rst=0): state IDLE; all outputs 0, including counters and cpu_read_data; ram_req deasserts asynchronously, mid-transaction abort without done/error.
- ram_req, ram_we, ram_address, ram_wdata are registered and stable from assertion until the cycle ram_ready is sampled; ram_req low the cycle after.
- ram_ready sampled only while ram_req=1; ready outside a request ignored.
- Read hit: request sampled cycle 0, strobe cycle 1, CHECK cycle 2, done cycle 3.
- Clean read miss, RAM ready after L cycles of req: done at cycle 4+L. Dirty read miss adds write-back latency + 1.
- Clean write miss: done cycle 3; no RAM traffic.
- New request accepted earliest the cycle after done/error.

## Structure
- cache_pkg: state enum, line_align(addr) function, default parameter constants.
- Sub-module sat_counter (WIDTH parameter, inc, async active-low reset) instantiated three times.

## Test plan
- Read hit, addr 0x0000_1040: cache_hit in cycle 2 -> done cycle 3, cpu_read_data = cache_read_data, hit_count=1, ram_req never high.
- Clean read miss addr 0x0000_2044, RAM ready after 5 cycles: ram_address=0x0000_2040, ram_we=0, cache_fill one cycle with ram_rdata, done cycle 9.
- Dirty read miss, evicted_address 0x0000_3000: write to 0x0000_3000 with evicted_data, then read of line; wb_count=1, miss_count=1.
- Write miss clean, cpu_read & cpu_write together: treated as write, done cycle 3, no ram_req.
- RAM never ready, TIMEOUT=8: error pulse once, ram_req drops, no done; next request served normally.
- rst low during FILL: ram_req low immediately, counters 0; hit_count held at 2^CNT_W-1 over further hits.

Source files
------------

// File: rtl/cache_ctrl_wb_pkg.sv
// Shared types and helpers for the write-back cache controller:
// FSM state encoding, default parameter values and line alignment.
package cache_ctrl_wb_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_LINE_W  = 512;
   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_CHECK     = 3'd2,
      S_WRITEBACK = 3'd3,
      S_FILL      = 3'd4,
      S_RESPOND   = 3'd5
   } state_e;

   function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offset_w);
      return addr & ~((64'd1 << offset_w) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_ctrl_wb_if.sv
// CPU, cache-array and RAM signals of the write-back controller.
// master = controller side, slave = surrounding CPU/cache/RAM system.
interface cache_ctrl_wb_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512,
   parameter int CNT_W  = 16
) ();
   logic              cpu_read, cpu_write, done, error, busy;
   logic [ADDR_W-1:0] cpu_address;
   logic [LINE_W-1:0] cpu_write_data, cpu_read_data;
   logic              cache_read, cache_write, cache_fill;
   logic [ADDR_W-1:0] cache_address, evicted_address;
   logic [LINE_W-1:0] cache_write_data, cache_read_data, evicted_data;
   logic              cache_hit, cache_miss, dirty_evicted;
   logic              ram_req, ram_we, ram_ready;
   logic [ADDR_W-1:0] ram_address;
   logic [LINE_W-1:0] ram_wdata, ram_rdata;
   logic [CNT_W-1:0]  hit_count, miss_count, wb_count;

   modport master (
      input  cpu_read, cpu_write, cpu_address, cpu_write_data,
             cache_hit, cache_miss, dirty_evicted, cache_read_data, evicted_data, evicted_address,
             ram_ready, ram_rdata,
      output cpu_read_data, done, error, busy,
             cache_read, cache_write, cache_fill, cache_address, cache_write_data,
             ram_req, ram_we, ram_address, ram_wdata,
             hit_count, miss_count, wb_count
   );

   modport slave (
      output cpu_read, cpu_write, cpu_address, cpu_write_data,
             cache_hit, cache_miss, dirty_evicted, cache_read_data, evicted_data, evicted_address,
             ram_ready, ram_rdata,
      input  cpu_read_data, done, error, busy,
             cache_read, cache_write, cache_fill, cache_address, cache_write_data,
             ram_req, ram_we, ram_address, ram_wdata,
             hit_count, miss_count, wb_count
   );
endinterface

// File: rtl/cache_ctrl_wb_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q, count_d;

   // next count, held once saturated
   always_comb begin
      if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back cache controller: one request at a time, dirty-line write-back,
// read-miss fill from RAM with a bounded wait, saturating statistics.
module cache_ctrl_wb
   import cache_ctrl_wb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LINE_W  = DEF_LINE_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic             clk_i,
   input logic             rst_ni,
   cache_ctrl_wb_if.master bus
);
   localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
   localparam int          WAIT_W   = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic              is_write_q, is_write_d, ram_req_q, ram_req_d, ram_we_q, ram_we_d, fill_q, fill_d;
   logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
   logic [LINE_W-1:0] rd_data_q, rd_data_d, wr_data_q, wr_data_d, ram_wdata_q, ram_wdata_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              ram_ack_s, waiting_s, progress_s, timeout_s;

   // ram_ready only counts while our own request is on the bus
   assign ram_ack_s  = ram_req_q & bus.ram_ready;
   assign waiting_s  = (state_q == S_CHECK) || (state_q == S_WRITEBACK) || (state_q == S_FILL);
   assign progress_s = (state_q == S_CHECK) ? (bus.cache_hit | bus.cache_miss) : ram_ack_s;
   assign timeout_s  = waiting_s && !progress_s && (wait_q == WAIT_W'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = (bus.cpu_read | bus.cpu_write) ? S_LOOKUP : S_IDLE;
         S_LOOKUP:    state_d = S_CHECK;
         S_CHECK: begin
            if (bus.cache_hit)          state_d = S_RESPOND;
            else if (bus.cache_miss)    state_d = bus.dirty_evicted ? S_WRITEBACK
                                                : (is_write_q ? S_RESPOND : S_FILL);
            else if (timeout_s)         state_d = S_IDLE;
            else                        state_d = S_CHECK;
         end
         S_WRITEBACK: begin
            if (ram_ack_s)              state_d = is_write_q ? S_RESPOND : S_FILL;
            else if (timeout_s)         state_d = S_IDLE;
            else                        state_d = S_WRITEBACK;
         end
         S_FILL: begin
            if (ram_ack_s)              state_d = S_RESPOND;
            else if (timeout_s)         state_d = S_IDLE;
            else                        state_d = S_FILL;
         end
         S_RESPOND:   state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // outputs decoded from state plus next values of the registered datapath
   always_comb begin
      bus.busy        = (state_q != S_IDLE);
      bus.cache_read  = (state_q == S_LOOKUP) && !is_write_q;
      bus.cache_write = (state_q == S_LOOKUP) && is_write_q;
      bus.done        = (state_q == S_RESPOND);
      bus.error       = timeout_s;
      is_write_d  = is_write_q;
      addr_d      = addr_q;
      rd_data_d   = rd_data_q;
      wr_data_d   = wr_data_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_req_d   = (state_d == S_WRITEBACK) || (state_d == S_FILL);
      ram_we_d    = (state_d == S_WRITEBACK);
      fill_d      = (state_q == S_FILL) && ram_ack_s;
      wait_d      = (waiting_s && (state_d == state_q)) ? wait_q + WAIT_W'(1) : {WAIT_W{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_read | bus.cpu_write) begin
               is_write_d = bus.cpu_write;
               addr_d     = bus.cpu_address;
               wr_data_d  = bus.cpu_write_data;
            end else begin
               is_write_d = is_write_q;
            end
         end
         S_CHECK: begin
            if (bus.cache_hit && !is_write_q) begin
               rd_data_d = bus.cache_read_data;
            end else begin
               rd_data_d = rd_data_q;
            end
            if (state_d == S_WRITEBACK) begin
               ram_addr_d  = ADDR_W'(line_align(64'(bus.evicted_address), OFFSET_W));
               ram_wdata_d = bus.evicted_data;
            end else if (state_d == S_FILL) begin
               ram_addr_d  = ADDR_W'(line_align(64'(addr_q), OFFSET_W));
            end else begin
               ram_addr_d  = ram_addr_q;
            end
         end
         S_WRITEBACK: begin
            // the fill request follows the write-back without a gap cycle
            if (state_d == S_FILL) begin
               ram_addr_d = ADDR_W'(line_align(64'(addr_q), OFFSET_W));
            end else begin
               ram_addr_d = ram_addr_q;
            end
         end
         S_FILL: begin
            if (ram_ack_s) begin
               rd_data_d = bus.ram_rdata;
               wr_data_d = bus.ram_rdata;
            end else begin
               rd_data_d = rd_data_q;
            end
         end
         default: begin
            addr_d = addr_q;
         end
      endcase
   end

   // datapath and RAM handshake registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         is_write_q  <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         rd_data_q   <= {LINE_W{1'b0}};
         wr_data_q   <= {LINE_W{1'b0}};
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= {ADDR_W{1'b0}};
         ram_wdata_q <= {LINE_W{1'b0}};
         fill_q      <= 1'b0;
         wait_q      <= {WAIT_W{1'b0}};
      end else begin
         is_write_q  <= is_write_d;
         addr_q      <= addr_d;
         rd_data_q   <= rd_data_d;
         wr_data_q   <= wr_data_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         fill_q      <= fill_d;
         wait_q      <= wait_d;
      end
   end

   assign bus.cpu_read_data    = rd_data_q;
   assign bus.cache_address    = addr_q;
   assign bus.cache_write_data = wr_data_q;
   assign bus.cache_fill       = fill_q;
   assign bus.ram_req          = ram_req_q;
   assign bus.ram_we           = ram_we_q;
   assign bus.ram_address      = ram_addr_q;
   assign bus.ram_wdata        = ram_wdata_q;

   sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .inc_i((state_q == S_CHECK) && bus.cache_hit), .count_o(bus.hit_count));
   sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .inc_i((state_q == S_CHECK) && !bus.cache_hit && bus.cache_miss), .count_o(bus.miss_count));
   sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .inc_i((state_q == S_WRITEBACK) && ram_ack_s), .count_o(bus.wb_count));
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Table-driven bench for cache_ctrl_wb with a reactive cache/RAM model and a
// completion scoreboard; small counters and TIMEOUT keep saturation/abort short.
module tb_cache_ctrl_wb;
   localparam int AW = 32, LW = 512, CW = 4, TO = 8, MAXC = 15;
   typedef logic [LW-1:0] line_t;

   typedef struct {
      string name; bit rd; bit wr; logic [31:0] addr; line_t wdata; int kind;
      logic [31:0] ev_addr; line_t ev_data; line_t c_rdata;
      int wb_lat; int fill_lat; line_t r_rdata; int abort_at;
      bit exp_err; int exp_cycle; line_t exp_rd; logic [31:0] exp_wb_addr; logic [31:0] exp_fill_addr;
      int exp_reqs; int exp_fills; int d_hit; int d_miss; int d_wb;
   } vec_t;

   typedef struct { bit is_err; int cycle; line_t rd; bit chk_rd; } sb_t;

   logic clk = 1'b0, rst_n = 1'b0;
   int   n_vec = 0, n_bad = 0;
   int   exp_hit = 0, exp_miss = 0, exp_wb = 0;
   sb_t  sb_q[$];
   vec_t vecs[11];
   line_t d[12];

   cache_ctrl_wb_if #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) bus ();
   cache_ctrl_wb #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input line_t act, input line_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                               input int kind, input int wb_lat, input int fill_lat, input bit err, input int cyc);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.kind = kind;
      v.wb_lat = wb_lat; v.fill_lat = fill_lat; v.exp_err = err; v.exp_cycle = cyc;
      v.wdata = '0; v.ev_addr = '0; v.ev_data = '0; v.c_rdata = '0; v.r_rdata = '0; v.abort_at = -1;
      v.exp_rd = '0; v.exp_wb_addr = '0; v.exp_fill_addr = '0;
      v.exp_reqs = 0; v.exp_fills = 0; v.d_hit = 0; v.d_miss = 0; v.d_wb = 0;
      return v;
   endfunction

   function automatic int sat(input int a, input int b);
      return (a + b > MAXC) ? MAXC : a + b;
   endfunction

   task automatic check_counts(input string name);
      check({name, "_hit_count"},  LW'(bus.hit_count),  LW'(exp_hit));
      check({name, "_miss_count"}, LW'(bus.miss_count), LW'(exp_miss));
      check({name, "_wb_count"},   LW'(bus.wb_count),   LW'(exp_wb));
   endtask

   // one transaction, driven and observed on falling edges, cycle 0 = request cycle
   task automatic run_vec(input vec_t v);
      int ev_cycle = -1, n_reqs = 0, n_fills = 0, req_cnt = 0, stuck = 0, lat;
      bit prev_req = 1'b0, prev_we = 1'b0, prev_ready = 1'b0, aborted = 1'b0;
      logic [31:0] prev_addr = '0;
      sb_t s;
      s.is_err = v.exp_err; s.cycle = v.exp_cycle; s.rd = v.exp_rd; s.chk_rd = v.rd && !v.wr && !v.exp_err;
      sb_q.push_back(s);
      for (int c = 0; c < 40; c++) begin
         bus.cpu_read  = (c == 0) ? v.rd : 1'b0;
         bus.cpu_write = (c == 0) ? v.wr : 1'b0;
         if (c == 0) begin bus.cpu_address = v.addr; bus.cpu_write_data = v.wdata; end
         bus.cache_hit     = (c == 2) && (v.kind == 0);
         bus.cache_miss    = (c == 2) && (v.kind == 1 || v.kind == 2);
         bus.dirty_evicted = (c == 2) && (v.kind == 2);
         if (c == 2) begin
            bus.cache_read_data = v.c_rdata; bus.evicted_address = v.ev_addr; bus.evicted_data = v.ev_data;
         end
         if (bus.ram_req) begin
            if (!prev_req || bus.ram_we !== prev_we || bus.ram_address !== prev_addr) begin
               req_cnt = 0; n_reqs++;
               if (bus.ram_we) begin
                  check({v.name, "_wb_addr"}, LW'(bus.ram_address), LW'(v.exp_wb_addr));
                  check({v.name, "_wb_data"}, bus.ram_wdata, v.ev_data);
               end else begin
                  check({v.name, "_fill_addr"}, LW'(bus.ram_address), LW'(v.exp_fill_addr));
               end
            end else begin
               req_cnt++;
               if (prev_ready) stuck++;
            end
            lat = bus.ram_we ? v.wb_lat : v.fill_lat;
            bus.ram_ready = (lat >= 0) && (req_cnt == lat);
            bus.ram_rdata = bus.ram_ready ? v.r_rdata : '0;
         end else begin
            bus.ram_ready = 1'b0;
         end
         prev_req = bus.ram_req; prev_we = bus.ram_we; prev_addr = bus.ram_address; prev_ready = bus.ram_ready;
         #1;
         if (c == 0) check({v.name, "_idle_busy"}, LW'(bus.busy), LW'(0));
         if (c == 1) begin
            check({v.name, "_strobe"}, LW'({bus.cache_read, bus.cache_write}), LW'({!v.wr, v.wr}));
            check({v.name, "_cache_addr"}, LW'(bus.cache_address), LW'(v.addr));
            if (v.wr) check({v.name, "_cache_wdata"}, bus.cache_write_data, v.wdata);
         end
         if (c == 2) check({v.name, "_strobe_off"}, LW'({bus.cache_read, bus.cache_write}), LW'(0));
         if (c == v.abort_at) begin
            check({v.name, "_pre_rst_req"}, LW'(bus.ram_req), LW'(1));
            rst_n = 1'b0; bus.ram_ready = 1'b0;
            #1;
            check({v.name, "_rst_outs"}, LW'({bus.ram_req, bus.busy, bus.done, bus.error, bus.cache_fill}), LW'(0));
            check({v.name, "_rst_rdata"}, bus.cpu_read_data, '0);
            exp_hit = 0; exp_miss = 0; exp_wb = 0;
            check_counts({v.name, "_rst"});
            @(posedge clk); @(negedge clk);
            rst_n = 1'b1;
            sb_q.delete();
            aborted = 1'b1;
            break;
         end
         if (bus.done || bus.error) begin
            if (sb_q.size() == 0) begin
               check({v.name, "_unexpected_event"}, LW'(c), LW'(-1));
            end else begin
               s = sb_q.pop_front();
               check({v.name, "_kind_err"}, LW'({bus.done, bus.error}), LW'({!s.is_err, s.is_err}));
               check({v.name, "_cycle"}, LW'(c), LW'(s.cycle));
               if (s.chk_rd) check({v.name, "_rdata"}, bus.cpu_read_data, s.rd);
            end
            ev_cycle = c;
         end
         if (bus.cache_fill) begin
            n_fills++;
            check({v.name, "_fill_data"}, bus.cache_write_data, v.r_rdata);
         end
         if (ev_cycle >= 0 && c == ev_cycle + 1) begin
            check({v.name, "_after"}, LW'({bus.busy, bus.ram_req, bus.done, bus.error}), LW'(0));
            break;
         end
         @(posedge clk); @(negedge clk);
      end
      if (!aborted) begin
         check({v.name, "_completion_pending"}, LW'(sb_q.size()), LW'(0));
         sb_q.delete();
         check({v.name, "_ram_reqs"}, LW'(n_reqs), LW'(v.exp_reqs));
         check({v.name, "_fills"}, LW'(n_fills), LW'(v.exp_fills));
         check({v.name, "_req_held"}, LW'(stuck), LW'(0));
         exp_hit = sat(exp_hit, v.d_hit); exp_miss = sat(exp_miss, v.d_miss); exp_wb = sat(exp_wb, v.d_wb);
         check_counts(v.name);
      end
   endtask

   initial begin
      logic [31:0] w;
      vec_t hv;
      for (int i = 0; i < 12; i++) begin
         w = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
         d[i] = {16{w}};
      end
      vecs[0] = mk("rd_hit", 1'b1, 1'b0, 32'h0000_1040, 0, -1, -1, 1'b0, 3);
      vecs[0].c_rdata = d[1]; vecs[0].exp_rd = d[1]; vecs[0].d_hit = 1;
      vecs[1] = mk("rd_clean_miss", 1'b1, 1'b0, 32'h0000_2044, 1, -1, 5, 1'b0, 9);
      vecs[1].r_rdata = d[2]; vecs[1].exp_rd = d[2]; vecs[1].exp_fill_addr = 32'h0000_2040;
      vecs[1].exp_reqs = 1; vecs[1].exp_fills = 1; vecs[1].d_miss = 1;
      vecs[2] = mk("rd_dirty_miss", 1'b1, 1'b0, 32'h0000_4010, 2, 3, 2, 1'b0, 10);
      vecs[2].ev_addr = 32'h0000_3000; vecs[2].ev_data = d[3]; vecs[2].r_rdata = d[4]; vecs[2].exp_rd = d[4];
      vecs[2].exp_wb_addr = 32'h0000_3000; vecs[2].exp_fill_addr = 32'h0000_4000;
      vecs[2].exp_reqs = 2; vecs[2].exp_fills = 1; vecs[2].d_miss = 1; vecs[2].d_wb = 1;
      vecs[3] = mk("wr_both_miss", 1'b1, 1'b1, 32'h0000_7008, 1, -1, 0, 1'b0, 3);
      vecs[3].wdata = d[5]; vecs[3].d_miss = 1;
      vecs[4] = mk("wr_hit", 1'b0, 1'b1, 32'h0000_1040, 0, -1, -1, 1'b0, 3);
      vecs[4].wdata = d[6]; vecs[4].d_hit = 1;
      vecs[5] = mk("wr_dirty_miss", 1'b0, 1'b1, 32'h0000_8000, 2, 2, -1, 1'b0, 6);
      vecs[5].wdata = d[7]; vecs[5].ev_addr = 32'h0000_5A7F; vecs[5].ev_data = d[8];
      vecs[5].exp_wb_addr = 32'h0000_5A40; vecs[5].exp_reqs = 1; vecs[5].d_miss = 1; vecs[5].d_wb = 1;
      vecs[6] = mk("fill_timeout", 1'b1, 1'b0, 32'h0000_6000, 1, -1, -1, 1'b1, 10);
      vecs[6].exp_fill_addr = 32'h0000_6000; vecs[6].exp_reqs = 1; vecs[6].d_miss = 1;
      vecs[7] = mk("wb_timeout", 1'b1, 1'b0, 32'h0000_9000, 2, -1, -1, 1'b1, 10);
      vecs[7].ev_addr = 32'h0000_A0C0; vecs[7].ev_data = d[9]; vecs[7].exp_wb_addr = 32'h0000_A0C0;
      vecs[7].exp_reqs = 1; vecs[7].d_miss = 1;
      vecs[8] = mk("check_timeout", 1'b1, 1'b0, 32'h0000_B000, 3, -1, -1, 1'b1, 9);
      vecs[9] = mk("rd_hit_after_err", 1'b1, 1'b0, 32'h0000_C0C0, 0, -1, -1, 1'b0, 3);
      vecs[9].c_rdata = d[10]; vecs[9].exp_rd = d[10]; vecs[9].d_hit = 1;
      vecs[10] = mk("rst_in_fill", 1'b1, 1'b0, 32'h0000_D044, 1, -1, -1, 1'b0, 0);
      vecs[10].abort_at = 5; vecs[10].exp_fill_addr = 32'h0000_D040;

      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_write_data = '0;
      bus.cache_hit = 1'b0; bus.cache_miss = 1'b0; bus.dirty_evicted = 1'b0;
      bus.cache_read_data = '0; bus.evicted_data = '0; bus.evicted_address = '0;
      bus.ram_ready = 1'b0; bus.ram_rdata = '0;
      repeat (3) @(negedge clk);
      check("reset_outs", LW'({bus.busy, bus.done, bus.error, bus.ram_req, bus.ram_we, bus.cache_read,
                               bus.cache_write, bus.cache_fill}), LW'(0));
      check("reset_rdata", bus.cpu_read_data, '0);
      check_counts("reset");
      rst_n = 1'b1;
      @(negedge clk);
      // stray ram_ready while idle must be ignored
      bus.ram_ready = 1'b1;
      @(negedge clk);
      check("stray_ready", LW'({bus.busy, bus.ram_req, bus.done, bus.error}), LW'(0));
      bus.ram_ready = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // saturation of the hit counter over repeated hits
      for (int i = 0; i < 17; i++) begin
         hv = mk("sat_hit", 1'b1, 1'b0, 32'h0000_E000 + 32'(i) * 32'h40, 0, -1, -1, 1'b0, 3);
         hv.c_rdata = d[i % 12]; hv.exp_rd = d[i % 12]; hv.d_hit = 1;
         run_vec(hv);
      end
      check("sat_final_hit", LW'(bus.hit_count), LW'(MAXC));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
